uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, entries per FIFO, power of two, legal 2..256.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rstn, input, 1, asynchronous active-low reset.
REQ-005 Port divisor, input, 16, baud tick period minus one, in clk cycles; ticks run at 16x baud.
REQ-006 Port parity_mode, input, 2: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-007 Port stop2, input, 1: 1 selects two stop bits, 0 selects one.
REQ-008 Port rx, input, 1, serial input, idle high, already synchronised externally.
REQ-009 Port rd_en, input, 1, pops one RX FIFO entry.
REQ-010 Port rx_data, output, DATA_BITS, head RX word, valid while rx_empty=0.
REQ-011 Port rx_perr / rx_ferr, output, 1 each, parity and framing error of the head RX word.
REQ-012 Port rx_empty, output, 1, RX FIFO empty.
REQ-013 Port rx_overrun, output, 1, sticky flag: a received word was dropped.
REQ-014 Port clr_overrun, input, 1, clears rx_overrun.
REQ-015 Port wr_en / wdata, input, 1 / DATA_BITS, pushes one TX word.
REQ-016 Port tx_full, output, 1, TX FIFO full.
REQ-017 Port tx, output, 1, serial output.
REQ-018 Port tx_busy, output, 1, transmitter is sending a frame.

Function
REQ-019 Baud generator: a one-cycle tick is asserted every divisor+1 clk cycles; divisor=0 gives a tick on every cycle.
REQ-020 FIFOs are show-ahead: head data is visible combinationally; pops and pushes take effect at the clock edge.
REQ-021 A push while full is ignored, except that push+pop in the same cycle on a full FIFO performs both.
REQ-022 A pop while empty is ignored; push+pop on an empty FIFO performs the push only.
REQ-023 RX FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-024 IDLE to START on rx=0; in START, rx is resampled at the 8th tick; rx=1 returns to IDLE (glitch reject), else go to DATA.
REQ-025 DATA samples DATA_BITS bits, LSB first, 16 ticks apart at bit centre.
REQ-026 PARITY is entered only when parity is enabled; the sampled bit is checked against even/odd parity of the data, and a mismatch sets perr.
REQ-027 STOP samples 1 or 2 stop bits at centre; any stop sample equal to 0 sets ferr.
REQ-028 At the final stop sample, {perr, ferr, data} is pushed into the RX FIFO and the FSM returns to IDLE.
REQ-029 If the RX FIFO is full at push time and there is no pop that cycle, the word is dropped and rx_overrun is set.
REQ-030 If set and clear of rx_overrun coincide, set wins.
REQ-031 TX FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-032 In IDLE with the TX FIFO not empty, the head word is popped and START is entered on the same edge.
REQ-033 TX bits are each 16 ticks long: start=0, then data LSB first, then the parity bit if enabled, then 1 or 2 stop bits of 1.
REQ-034 After the last stop bit, TX returns to IDLE; a non-empty FIFO starts the next frame with no idle gap.
REQ-035 tx_busy=1 in every TX state except IDLE.
REQ-036 parity_mode and stop2 are latched at frame start (START entry) per direction; changes mid-frame do not affect the current frame.
REQ-037 A divisor change takes effect when the baud counter next wraps.

Reset
REQ-038 rstn low asynchronously forces: tx=1, tx_busy=0, both FSMs IDLE, both FIFOs empty (rx_empty=1, tx_full=0), rx_overrun=0, rx_perr=0, rx_ferr=0, rx_data=0, baud counter=0.
REQ-039 Reset mid-frame discards the partial frame; no word is pushed on reset release.

Structure
REQ-040 The shared package uart_pkg holds FSM state typedefs, parity_mode encodings and the OVERSAMPLE=16 constant.
REQ-041 A single sub-module uart_fifo (parameters WIDTH, DEPTH; full/empty outputs) is instantiated twice: RX with WIDTH=DATA_BITS+2, TX with WIDTH=DATA_BITS.

Verification
REQ-042 Loopback (tx tied to rx), divisor=3, parity none, one stop bit, write 0xA5 -> 0xA5 read back with perr=0 and ferr=0; frame lasts 10x16x4 = 640 cycles.
REQ-043 Odd parity, send 0x03 -> tx parity bit=1; receive 0x03 with parity bit 0 -> rx_perr=1.
REQ-044 Receive 0x55 with stop bit driven 0 -> rx_ferr=1; a 3-tick low glitch on rx -> no word pushed.
REQ-045 Receive FIFO_DEPTH+1 frames with no reads -> first 16 words retained, rx_overrun=1; clr_overrun -> 0.
REQ-046 Write 3 words back-to-back, stop2=1 -> 3 contiguous frames of 11 bits, no idle gap; tx_busy falls after the third frame.
REQ-047 Assert rstn low mid TX data bit -> tx=1 immediately and the FIFO empties; a mid-RX reset leaves rx_empty=1 after release.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encodings and parity helpers for uart_core
// Contents: OVERSAMPLE, parity_mode encodings, state_t, par_en(), par_bit()
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  // parity_mode encodings; any other value means no parity bit
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD = 2'b10;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP = 3'd4;
  function automatic logic par_en(input logic [1:0] m);
    return m == PAR_EVEN || m == PAR_ODD;
  endfunction
  // data is zero-extended to 9 bits, which leaves its parity unchanged
  function automatic logic par_bit(input logic [8:0] d, input logic [1:0] m);
    return (^d) ^ (m == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: show-ahead synchronous FIFO with full/empty flags
// Ports: clk, rstn (async active-low), i_push/i_wdata write side,
//        i_pop/o_rdata read side (o_rdata reads 0 while empty), o_full, o_empty
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop = i_pop && !o_empty;
  // a simultaneous pop frees the slot being written, so push+pop on full is allowed
  assign w_push = i_push && (!o_full || i_pop);
  assign o_rdata = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + {{AW{1'b0}}, w_push};
      r_rd <= r_rd + {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/uart_core.sv
// uart_core: 16x-oversampled UART with RX/TX FIFOs, optional parity and 1/2 stop bits
// Ports: clk, rstn (async active-low), divisor (tick period - 1), parity_mode, stop2,
//        rx/rd_en -> rx_data, rx_perr, rx_ferr, rx_empty, rx_overrun (clr_overrun),
//        wr_en/wdata -> tx_full, tx, tx_busy
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [15:0]          divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  input  logic                 clr_overrun,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 tx_full,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  // the detection tick is the first start-bit tick, so the 8th lands at count 6
  localparam logic [3:0] START_TICK = 4'(OVERSAMPLE / 2 - 2);
  logic [15:0] r_baud_cnt, r_div;
  logic w_tick;
  // divisor is only sampled on wrap so a change never truncates a tick period
  assign w_tick = r_baud_cnt == r_div;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_baud_cnt <= '0;
      r_div <= '0;
    end else begin
      r_baud_cnt <= w_tick ? '0 : r_baud_cnt + 16'd1;
      r_div <= w_tick ? divisor : r_div;
    end
  state_t r_rx_st;
  logic [3:0] r_rx_cnt, r_rx_bits;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [1:0] r_rx_pm;
  logic r_rx_s2, r_rx_perr, r_rx_ferr, r_ovr;
  logic w_rx_mid, w_rx_last, w_rx_full;
  logic [DATA_BITS+1:0] w_rx_word, w_rx_head;
  assign w_rx_mid = w_tick && r_rx_cnt == LAST_TICK;
  assign w_rx_last = r_rx_st == ST_STOP && w_rx_mid && !(r_rx_s2 && r_rx_bits == 4'd0);
  // the final stop sample is folded into ferr on the same edge it is pushed
  assign w_rx_word = {r_rx_perr, r_rx_ferr | !rx, r_rx_shift};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_rx_st <= ST_IDLE;
      r_rx_cnt <= '0;
      r_rx_bits <= '0;
      r_rx_shift <= '0;
      r_rx_pm <= '0;
      r_rx_s2 <= 1'b0;
      r_rx_perr <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else if (w_tick) begin
      r_rx_cnt <= r_rx_cnt + 4'd1;
      case (r_rx_st)
        ST_IDLE: if (!rx) begin
          r_rx_st <= ST_START;
          r_rx_cnt <= '0;
          r_rx_bits <= '0;
          r_rx_pm <= parity_mode;
          r_rx_s2 <= stop2;
          r_rx_perr <= 1'b0;
          r_rx_ferr <= 1'b0;
        end
        ST_START: if (r_rx_cnt == START_TICK) begin
          r_rx_cnt <= '0;
          r_rx_st <= rx ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (w_rx_mid) begin
          r_rx_shift <= {rx, r_rx_shift[DATA_BITS-1:1]};
          r_rx_bits <= r_rx_bits == LAST_BIT ? 4'd0 : r_rx_bits + 4'd1;
          r_rx_st <= r_rx_bits != LAST_BIT ? ST_DATA : par_en(r_rx_pm) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (w_rx_mid) begin
          r_rx_perr <= rx ^ par_bit(9'(r_rx_shift), r_rx_pm);
          r_rx_st <= ST_STOP;
        end
        ST_STOP: if (w_rx_mid) begin
          r_rx_ferr <= r_rx_ferr | !rx;
          r_rx_bits <= r_rx_bits + 4'd1;
          r_rx_st <= w_rx_last ? ST_IDLE : ST_STOP;
        end
        default: r_rx_st <= ST_IDLE;
      endcase
    end
  uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk),
    .rstn(rstn),
    .i_push(w_rx_last),
    .i_wdata(w_rx_word),
    .i_pop(rd_en),
    .o_rdata(w_rx_head),
    .o_full(w_rx_full),
    .o_empty(rx_empty)
  );
  assign {rx_perr, rx_ferr, rx_data} = w_rx_head;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_ovr <= 1'b0;
    else r_ovr <= (w_rx_last && w_rx_full && !rd_en) || (r_ovr && !clr_overrun);
  assign rx_overrun = r_ovr;
  state_t r_tx_st;
  logic [3:0] r_tx_cnt, r_tx_bits;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_head;
  logic [1:0] r_tx_pm;
  logic r_tx_s2, r_tx_pbit;
  logic w_tx_empty, w_tx_mid, w_tx_end, w_tx_load;
  assign w_tx_mid = w_tick && r_tx_cnt == LAST_TICK;
  assign w_tx_end = r_tx_st == ST_STOP && w_tx_mid && !(r_tx_s2 && r_tx_bits == 4'd0);
  // chaining straight from the last stop bit into the next start bit avoids an idle clock
  assign w_tx_load = !w_tx_empty && (r_tx_st == ST_IDLE || w_tx_end);
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk),
    .rstn(rstn),
    .i_push(wr_en),
    .i_wdata(wdata),
    .i_pop(w_tx_load),
    .o_rdata(w_tx_head),
    .o_full(tx_full),
    .o_empty(w_tx_empty)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_tx_st <= ST_IDLE;
      r_tx_cnt <= '0;
      r_tx_bits <= '0;
      r_tx_shift <= '0;
      r_tx_pm <= '0;
      r_tx_s2 <= 1'b0;
      r_tx_pbit <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_st <= ST_START;
      r_tx_cnt <= '0;
      r_tx_bits <= '0;
      r_tx_shift <= w_tx_head;
      r_tx_pm <= parity_mode;
      r_tx_s2 <= stop2;
      r_tx_pbit <= par_bit(9'(w_tx_head), parity_mode);
    end else if (w_tick && r_tx_st != ST_IDLE) begin
      r_tx_cnt <= r_tx_cnt + 4'd1;
      if (w_tx_mid)
        case (r_tx_st)
          ST_START: r_tx_st <= ST_DATA;
          ST_DATA: begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bits <= r_tx_bits == LAST_BIT ? 4'd0 : r_tx_bits + 4'd1;
            r_tx_st <= r_tx_bits != LAST_BIT ? ST_DATA : par_en(r_tx_pm) ? ST_PARITY : ST_STOP;
          end
          ST_PARITY: r_tx_st <= ST_STOP;
          ST_STOP: begin
            r_tx_bits <= r_tx_bits + 4'd1;
            r_tx_st <= w_tx_end ? ST_IDLE : ST_STOP;
          end
          default: r_tx_st <= ST_IDLE;
        endcase
    end
  assign tx = r_tx_st == ST_START ? 1'b0 : r_tx_st == ST_DATA ? r_tx_shift[0] : r_tx_st == ST_PARITY ? r_tx_pbit : 1'b1;
  assign tx_busy = r_tx_st != ST_IDLE;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: vector table, loopback with random frames, and corner sequences for uart_core
module tb_uart_core;
  localparam int DB = 8;
  localparam int DEPTH = 16;
  localparam int DIV = 3;
  localparam int BIT = 16 * (DIV + 1);
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] pm;
    logic s2, bp, bs, pe, fe;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0, stop2 = 1'b0, r_rx = 1'b1, rd_en = 1'b0;
  logic clr_overrun = 1'b0, wr_en = 1'b0, loop = 1'b0;
  logic [15:0] divisor = 16'(DIV);
  logic [1:0] parity_mode = 2'b00;
  logic [DB-1:0] wdata = '0, rx_data;
  logic rx_perr, rx_ferr, rx_empty, rx_overrun, tx_full, tx, tx_busy, rx;
  int n_chk = 0, n_pass = 0;
  vec_t tv [8];
  assign rx = loop ? tx : r_rx;
  always #5 clk = ~clk;
  uart_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .divisor(divisor), .parity_mode(parity_mode), .stop2(stop2),
    .rx(rx), .rd_en(rd_en), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_empty(rx_empty), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun),
    .wr_en(wr_en), .wdata(wdata), .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  // frame bit list, index 0 first on the wire; unused upper bits stay 1
  function automatic int mk_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2, output logic [11:0] f);
    int n;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    n = 9;
    if (pm == 2'b01 || pm == 2'b10) begin
      f[9] = (^d) ^ (pm == 2'b10);
      n = 10;
    end
    return n + (s2 ? 2 : 1);
  endfunction
  task automatic send_rx(input logic [7:0] d, input logic [1:0] pm, input logic s2, input logic bp, input logic bs);
    logic [11:0] f;
    int n, sb;
    n = mk_frame(d, pm, s2, f);
    sb = n - (s2 ? 2 : 1);
    if (bp) f[9] = ~f[9];
    parity_mode = pm;
    stop2 = s2;
    for (int i = 0; i < n; i++) begin
      r_rx = f[i];
      if (bs && i == sb) begin
        r_rx = 1'b0;
        wclk(BIT * 3 / 4);
        r_rx = 1'b1;
        wclk(BIT / 4);
      end else wclk(BIT);
    end
    wclk(4);
  endtask
  task automatic pop_chk(input string nm, input logic [7:0] d, input logic pe, input logic fe);
    chk({nm, "_empty"}, rx_empty, 0);
    chk({nm, "_data"}, rx_data, d);
    chk({nm, "_perr"}, rx_perr, pe);
    chk({nm, "_ferr"}, rx_ferr, fe);
    rd_en = 1'b1;
    wclk(1);
    rd_en = 1'b0;
  endtask
  task automatic push(input logic [7:0] d);
    wdata = d;
    wr_en = 1'b1;
    wclk(1);
    wr_en = 1'b0;
  endtask
  task automatic busy_len(output int len);
    int w;
    w = 0;
    while (!tx_busy && w < 200) begin wclk(1); w++; end
    len = 0;
    while (tx_busy && len < 20000) begin wclk(1); len++; end
  endtask
  task automatic wait_idle();
    int w;
    w = 0;
    while (tx_busy && w < 20000) begin wclk(1); w++; end
    chk("tx_idle_timeout", tx_busy, 0);
    wclk(8);
  endtask
  task automatic cap_tx(input int n, output logic [11:0] c);
    int w;
    w = 0;
    c = '1;
    while (tx !== 1'b0 && w < BIT * 16) begin wclk(1); w++; end
    chk("tx_start_seen", tx, 0);
    for (int i = 0; i < n; i++) begin
      wclk(i == 0 ? BIT / 2 : BIT);
      c[i] = tx;
    end
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [11:0] f, c;
    logic [7:0] q[$];
    logic [1:0] pm;
    logic s2;
    int n, k, len;
    tv[0] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[2] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{8'hA5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4] = '{8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[5] = '{8'hFF, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[6] = '{8'h80, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7] = '{8'h00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wclk(3);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_perr", rx_perr, 0);
    chk("rst_ferr", rx_ferr, 0);
    chk("rst_rx_data", rx_data, 0);
    rstn = 1'b1;
    wclk(4);
    for (int i = 0; i < 8; i++) begin
      send_rx(tv[i].d, tv[i].pm, tv[i].s2, tv[i].bp, tv[i].bs);
      pop_chk("vec", tv[i].d, tv[i].pe, tv[i].fe);
      chk("vec_empty_after", rx_empty, 1);
    end
    r_rx = 1'b0;
    wclk(3 * (DIV + 1));
    r_rx = 1'b1;
    wclk(BIT * 2);
    chk("glitch_no_word", rx_empty, 1);
    loop = 1'b1;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    push(8'hA5);
    busy_len(len);
    chk("a5_frame_len", len >= 630 && len <= 645, 1);
    wclk(8);
    pop_chk("a5_loop", 8'hA5, 0, 0);
    parity_mode = 2'b10;
    push(8'h03);
    n = mk_frame(8'h03, 2'b10, 1'b0, f);
    cap_tx(n, c);
    chk("odd_par_bit", c[9], 1);
    chk("odd_frame", c, f);
    wait_idle();
    pop_chk("odd_loop", 8'h03, 0, 0);
    for (int b = 0; b < 3; b++) begin
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 4);
      parity_mode = pm;
      stop2 = s2;
      q.delete();
      for (int j = 0; j < k; j++) q.push_back(8'($urandom));
      foreach (q[j]) push(q[j]);
      foreach (q[j]) begin
        n = mk_frame(q[j], pm, s2, f);
        cap_tx(n, c);
        chk("rnd_frame", c, f);
      end
      wait_idle();
      foreach (q[j]) pop_chk("rnd_loop", q[j], 0, 0);
      chk("rnd_empty", rx_empty, 1);
    end
    parity_mode = 2'b00;
    stop2 = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    busy_len(len);
    chk("contig_len", len >= 2096 && len <= 2116, 1);
    chk("contig_busy_fall", tx_busy, 0);
    wclk(8);
    pop_chk("contig0", 8'h11, 0, 0);
    pop_chk("contig1", 8'h22, 0, 0);
    pop_chk("contig2", 8'h33, 0, 0);
    loop = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_rx(8'(i + 1), 2'b00, 1'b0, 1'b0, 1'b0);
      if (i == DEPTH - 1) chk("ovr_not_yet", rx_overrun, 0);
    end
    chk("ovr_set", rx_overrun, 1);
    for (int i = 0; i < DEPTH; i++) pop_chk("ovr_word", 8'(i + 1), 0, 0);
    chk("ovr_drained", rx_empty, 1);
    chk("ovr_sticky", rx_overrun, 1);
    clr_overrun = 1'b1;
    wclk(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared", rx_overrun, 0);
    parity_mode = 2'b00;
    stop2 = 1'b0;
    push(8'h0F);
    push(8'hF0);
    push(8'h5A);
    wclk(BIT * 3);
    chk("rst_mid_busy", tx_busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", tx_busy, 0);
    chk("rst_async_full", tx_full, 0);
    wclk(2);
    rstn = 1'b1;
    wclk(100);
    chk("rst_fifo_flushed", tx_busy, 0);
    chk("rst_tx_idle", tx, 1);
    r_rx = 1'b0;
    wclk(BIT * 2 + BIT / 2);
    rstn = 1'b0;
    r_rx = 1'b1;
    wclk(2);
    rstn = 1'b1;
    wclk(BIT * 12);
    chk("rx_rst_empty", rx_empty, 1);
    chk("rx_rst_data", rx_data, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
